// File: rtl/approx_acc_stage.sv
// ---------------------------------------------------------------------------
// approx_acc_stage
//
// Frame accumulator placed behind an 8x8 approximate multiplier. Unsigned
// 16-bit products arrive one beat at a time. The block sums them into an
// ACC_W-bit accumulator and counts the beats. A frame closes when a beat
// carries in_last, or when the beat counter reaches its all-ones limit.
// On close, the result is held on the output side until the consumer takes it.
//
// Optional feature macro: APPROX_ACC_SATURATE_EN
//   defined   : an overflowing addition clamps the sum to 2^ACC_W-1, and the
//               sum stays there for the rest of the frame
//   undefined : the sum wraps modulo 2^ACC_W (default build)
//   In both builds out_ovf flags that an overflow happened.
//
// Parameters
//   ACC_W     accumulator width, 17..32
//   LEN_W     beat-counter width, 2..16 (frame limit is 2^LEN_W-1 beats)
//
// Ports
//   clk       single clock, rising-edge active
//   rst       synchronous active-high reset; drops any partial/pending frame
//   in_valid  in_prod / in_last carry a beat
//   in_ready  block takes a beat this cycle (ACCUM state, not in reset)
//   in_prod   16-bit unsigned product
//   in_last   beat closes the frame
//   out_valid frame result is presented (HOLD state)
//   out_ready consumer takes the result
//   out_sum   accumulated frame sum
//   out_count number of beats in the frame
//   out_ovf   sum overflowed ACC_W bits during the frame (sticky)
//   out_trunc frame was closed by the counter limit rather than by in_last
// ---------------------------------------------------------------------------
module approx_acc_stage #(
  parameter int ACC_W = 24,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_prod,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [LEN_W-1:0] out_count,
  output logic             out_ovf,
  output logic             out_trunc
);

  // The product is zero-extended by this many bits to reach the carry-out
  // position of the accumulator adder.
  localparam int PAD_W = ACC_W - 15;

  localparam logic [LEN_W-1:0] CNT_ONE   = {{(LEN_W-1){1'b0}}, 1'b1};
  localparam logic [LEN_W-1:0] CNT_LIMIT = {LEN_W{1'b1}};
  // The count before the beat that would reach the limit.
  localparam logic [LEN_W-1:0] CNT_LAST  = CNT_LIMIT - CNT_ONE;
`ifdef APPROX_ACC_SATURATE_EN
  localparam logic [ACC_W-1:0] ACC_MAX   = {ACC_W{1'b1}};
`endif

  typedef enum logic [0:0] {
    ST_ACCUM = 1'b0,
    ST_HOLD  = 1'b1
  } state_e;

  state_e           r_state;
  state_e           w_state_nxt;

  logic [ACC_W-1:0] r_acc;
  logic [LEN_W-1:0] r_count;
  logic             r_ovf;
  logic             r_trunc;

  logic             w_in_ready;
  logic             w_out_valid;
  logic             w_accept;
  logic             w_release;
  logic             w_limit;
  logic             w_close;
  logic             w_carry;
  logic [ACC_W:0]   w_sum_ext;
  logic [ACC_W-1:0] w_acc_nxt;

  // Unsigned add that keeps the carry-out as the top bit.
  function automatic logic [ACC_W:0] add_ext(input logic [ACC_W-1:0] acc,
                                             input logic [15:0]      prod);
    add_ext = {1'b0, acc} + {{PAD_W{1'b0}}, prod};
  endfunction

  // The handshake terms use only the state-decoded ready/valid. Neither of
  // them has a combinational path back into in_ready or out_valid.
  assign w_accept  = in_valid & w_in_ready;
  assign w_release = w_out_valid & out_ready;

  // The beat now being accepted would bring the count to the limit.
  assign w_limit   = (r_count == CNT_LAST);
  assign w_close   = in_last | w_limit;

  assign w_sum_ext = add_ext(r_acc, in_prod);
  assign w_carry   = w_sum_ext[ACC_W];

  // Select the next accumulator value when an addition overflows.
  always_comb begin
    w_acc_nxt = w_sum_ext[ACC_W-1:0];
`ifdef APPROX_ACC_SATURATE_EN
    // Once the frame has overflowed, it stays pinned at full scale.
    if (w_carry || r_ovf) begin
      w_acc_nxt = ACC_MAX;
    end else begin
      w_acc_nxt = w_sum_ext[ACC_W-1:0];
    end
`endif
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_ACCUM;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_ACCUM: begin
        if (w_accept && w_close) begin
          w_state_nxt = ST_HOLD;
        end else begin
          w_state_nxt = ST_ACCUM;
        end
      end
      ST_HOLD: begin
        if (w_release) begin
          w_state_nxt = ST_ACCUM;
        end else begin
          w_state_nxt = ST_HOLD;
        end
      end
      default: begin
        w_state_nxt = ST_ACCUM;
      end
    endcase
  end

  // FSM output decode. The ready/valid pair comes from the state register.
  // in_ready is also masked by rst, so no beat is taken during reset.
  always_comb begin
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    case (r_state)
      ST_ACCUM: begin
        w_in_ready  = ~rst;
        w_out_valid = 1'b0;
      end
      ST_HOLD: begin
        w_in_ready  = 1'b0;
        w_out_valid = 1'b1;
      end
      default: begin
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
      end
    endcase
  end

  // Accumulator, beat counter and the sticky overflow / truncation flags.
  // They hold still in HOLD, so the result stays stable until it is taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc   <= {ACC_W{1'b0}};
      r_count <= {LEN_W{1'b0}};
      r_ovf   <= 1'b0;
      r_trunc <= 1'b0;
    end else if (w_release) begin
      r_acc   <= {ACC_W{1'b0}};
      r_count <= {LEN_W{1'b0}};
      r_ovf   <= 1'b0;
      r_trunc <= 1'b0;
    end else if (w_accept) begin
      r_acc   <= w_acc_nxt;
      r_count <= r_count + CNT_ONE;
      r_ovf   <= r_ovf | w_carry;
      // Only a limit close that in_last did not ask for counts as truncation.
      r_trunc <= w_limit & ~in_last;
    end else begin
      r_acc   <= r_acc;
      r_count <= r_count;
      r_ovf   <= r_ovf;
      r_trunc <= r_trunc;
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = w_out_valid;
  assign out_sum   = r_acc;
  assign out_count = r_count;
  assign out_ovf   = r_ovf;
  assign out_trunc = r_trunc;

endmodule

// File: doc/approx_acc_stage.md
APPROX_ACC_STAGE -- requirements
Module: approx_acc_stage

Interface
REQ-001 The block SHALL have parameter ACC_W, default 24, giving the accumulator width in bits (legal 17..32).
REQ-002 The block SHALL have parameter LEN_W, default 8, giving the beat-counter width in bits (legal 2..16).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port in_valid, input, 1 bit: in_prod/in_last are valid.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block accepts a beat this cycle.
REQ-007 The block SHALL have port in_prod, input, 16 bits: unsigned product from the 8x8 approximate multiplier.
REQ-008 The block SHALL have port in_last, input, 1 bit: this beat closes the frame.
REQ-009 The block SHALL have port out_valid, output, 1 bit: the frame result is valid.
REQ-010 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-011 The block SHALL have port out_sum, output, ACC_W bits: accumulated frame sum.
REQ-012 The block SHALL have port out_count, output, LEN_W bits: number of beats in the frame.
REQ-013 The block SHALL have port out_ovf, output, 1 bit: the sum overflowed ACC_W during the frame.
REQ-014 The block SHALL have port out_trunc, output, 1 bit: the frame was closed by counter limit, not by in_last.

Function
REQ-015 The block SHALL implement a two-state FSM: ACCUM (in_ready=1, out_valid=0) and HOLD (in_ready=0, out_valid=1).
REQ-016 A beat SHALL be accepted only when in_valid && in_ready; in ACCUM it sets acc <= acc + zero-extended in_prod and count <= count + 1.
REQ-017 An accepted beat with in_last=1 SHALL move ACCUM->HOLD, with out_valid=1 in the next cycle (latency 1 cycle from the last beat).
REQ-018 When an accepted beat brings count to 2^LEN_W-1 and in_last=0, the block SHALL close the frame as in REQ-017 and set out_trunc=1.
REQ-019 If in_last=1 on the limit beat, out_trunc SHALL be 0.
REQ-020 In HOLD, out_sum/out_count/out_ovf/out_trunc SHALL be held stable until out_valid && out_ready.
REQ-021 On the HOLD handshake the block SHALL clear acc, count, ovf and trunc and return to ACCUM in the next cycle; no input beat is accepted in that same cycle.
REQ-022 out_ovf SHALL be sticky within a frame: set by any accepted beat whose addition carries beyond ACC_W bits.
REQ-023 in_valid, in_prod and in_last SHALL be ignored while in HOLD or under reset.
REQ-024 in_ready and out_valid SHALL be decoded from the state register only (no combinational path from in_valid or out_ready).

Reset
REQ-025 While rst=1 at a rising edge the block SHALL enter ACCUM with acc=0, count=0, ovf=0, trunc=0.
REQ-026 After reset: out_valid=0, out_sum=0, out_count=0, out_ovf=0, out_trunc=0; in_ready=0 during any cycle with rst=1, 1 after.
REQ-027 Reset mid-frame or in HOLD SHALL discard the partial or pending result without emitting it.

Configuration
REQ-028 Macro APPROX_ACC_SATURATE_EN SHALL select overflow behaviour.
REQ-029 With APPROX_ACC_SATURATE_EN defined, an overflowing addition SHALL clamp acc to 2^ACC_W-1 and hold it there for the rest of the frame; out_ovf=1.
REQ-030 Without APPROX_ACC_SATURATE_EN, acc SHALL wrap modulo 2^ACC_W; out_ovf=1.

Verification
REQ-031 ACC_W=24: beats 0x0006, 0x0010, 0xFFFF (last on third), out_ready=1 -> out_sum=0x010015, out_count=3, out_ovf=0, out_trunc=0, out_valid one cycle after the third beat.
REQ-032 ACC_W=17: beats 0xFFFF, 0xFFFF, 0x0003 (last) -> out_sum=0x00001, out_ovf=1 without macro; out_sum=0x1FFFF, out_ovf=1 with APPROX_ACC_SATURATE_EN.
REQ-033 Single beat 0x1234 last, out_ready held low 5 cycles -> out_valid=1 and out_sum=0x001234 stable for all 5 cycles, in_ready=0; handshake on cycle 6, in_ready=1 the cycle after.
REQ-034 LEN_W=8: 255 beats of 0x0001, in_last never set -> out_sum=0x0000FF, out_count=255, out_trunc=1.
REQ-035 Beats 0x0005, 0x0007, then rst for 1 cycle, then beat 0x0004 last -> out_sum=0x000004, out_count=1, no result emitted for the aborted frame.
REQ-036 Back-to-back frames with in_valid held high: frame A (0x0002 last) and frame B (0x0003 last) -> two results 2 then 3, with no beat accepted during HOLD.
